// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parametrised MIPS register file.
package regfile_pkg;

    // Flush engine states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } flush_state_e;

    // Byte-lane merge: take the incoming byte where its enable is set,
    // otherwise keep the stored byte.
    function automatic logic [7:0] byte_merge(
        input logic [7:0] old_byte,
        input logic [7:0] new_byte,
        input logic       be
    );
        return be ? new_byte : old_byte;
    endfunction

    // True when the address names the hardwired-zero register.
    function automatic logic is_hardwired_zero(
        input int unsigned addr,
        input int unsigned zero_reg
    );
        return (zero_reg != 0) && (addr == 0);
    endfunction

endpackage

// File: rtl/regfile_flush_fsm.sv
// Sequential flush engine: walks the array one entry per cycle, then
// pulses flush_done for a single cycle before returning to IDLE.
module regfile_flush_fsm
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned PTR_W    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_req,
    output logic             flush_busy,
    output logic             flush_done,
    output logic             clr_en,
    output logic [PTR_W-1:0] clr_addr
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_REGS - 1);

    flush_state_e     state;
    flush_state_e     state_next;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_next;

    // State and pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    // Next-state: request sampled only in IDLE; DONE always passes through IDLE
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        unique case (state)
            IDLE: begin
                if (flush_req) begin
                    state_next = CLEAR;
                    ptr_next   = '0;
                end
            end
            CLEAR: begin
                if (ptr == LAST_PTR) begin
                    state_next = DONE;
                    ptr_next   = '0;
                end else begin
                    ptr_next = ptr + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                ptr_next   = '0;
            end
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        flush_busy = (state == CLEAR);
        flush_done = (state == DONE);
        clr_en     = (state == CLEAR);
        clr_addr   = ptr;
    end

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file with byte-enabled writes, optional hardwired
// zero register, optional write-to-read bypass and a sequential flush engine.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   rd_addr1,
    input  logic [ADDR_W-1:0]   rd_addr2,
    output logic [DATA_W-1:0]   rd_data1,
    output logic [DATA_W-1:0]   rd_data2,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                flush_req,
    output logic                flush_busy,
    output logic                flush_done
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic              clr_en;
    logic [IDX_W-1:0]  clr_addr;

    logic              wr_in_range;
    logic              wr_ok;
    logic [DATA_W-1:0] wr_old;
    logic [DATA_W-1:0] wr_merged;

    logic              rd1_visible;
    logic              rd2_visible;

    regfile_flush_fsm #(
        .NUM_REGS (NUM_REGS),
        .PTR_W    (IDX_W)
    ) u_flush_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_req  (flush_req),
        .flush_busy (flush_busy),
        .flush_done (flush_done),
        .clr_en     (clr_en),
        .clr_addr   (clr_addr)
    );

    // Write acceptance: enabled, not flushing, in range, not the zero register
    always_comb begin
        wr_in_range = (32'(wr_addr) < NUM_REGS);
        wr_ok       = wr_en && !flush_busy && wr_in_range &&
                      !is_hardwired_zero(32'(wr_addr), ZERO_REG);
    end

    // Stored value at the write address, used as the base for the byte merge
    always_comb begin
        wr_old = '0;
        if (wr_in_range) begin
            wr_old = regs[wr_addr[IDX_W-1:0]];
        end
    end

    for (genvar g = 0; g < BE_W; g++) begin : g_lane
        assign wr_merged[8*g +: 8] = byte_merge(wr_old[8*g +: 8], wr_data[8*g +: 8], wr_be[g]);
    end

    // Array update: reset clears everything, flush clears one entry per cycle.
    // Flush clears and accepted writes never coincide since writes are
    // refused while the flush engine is busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[IDX_W'(i)] <= '0;
            end
        end else begin
            if (clr_en) begin
                regs[clr_addr] <= '0;
            end
            if (wr_ok) begin
                regs[wr_addr[IDX_W-1:0]] <= wr_merged;
            end
        end
    end

    // Which read addresses map onto real, non-hardwired registers
    always_comb begin
        rd1_visible = (32'(rd_addr1) < NUM_REGS) &&
                      !is_hardwired_zero(32'(rd_addr1), ZERO_REG);
        rd2_visible = (32'(rd_addr2) < NUM_REGS) &&
                      !is_hardwired_zero(32'(rd_addr2), ZERO_REG);
    end

    // Read port 1: stored contents, overridden by the merged write when bypassing
    always_comb begin
        rd_data1 = '0;
        if (rd1_visible) begin
            rd_data1 = regs[rd_addr1[IDX_W-1:0]];
        end
        if ((BYPASS != 0) && wr_ok && (rd_addr1 == wr_addr)) begin
            rd_data1 = wr_merged;
        end
    end

    // Read port 2: stored contents, overridden by the merged write when bypassing
    always_comb begin
        rd_data2 = '0;
        if (rd2_visible) begin
            rd_data2 = regs[rd_addr2[IDX_W-1:0]];
        end
        if ((BYPASS != 0) && wr_ok && (rd_addr2 == wr_addr)) begin
            rd_data2 = wr_merged;
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param: three configurations share stimulus;
// expectations are queued per cycle and checked by an independent monitor.
module tb_regfile_param;

    localparam int unsigned S_A_RD1  = 0;
    localparam int unsigned S_A_RD2  = 1;
    localparam int unsigned S_A_BUSY = 2;
    localparam int unsigned S_A_DONE = 3;
    localparam int unsigned S_B_RD1  = 4;
    localparam int unsigned S_B_RD2  = 5;
    localparam int unsigned S_B_BUSY = 6;
    localparam int unsigned S_B_DONE = 7;
    localparam int unsigned S_C_RD1  = 8;
    localparam int unsigned S_C_RD2  = 9;
    localparam int unsigned S_C_BUSY = 10;
    localparam int unsigned S_C_DONE = 11;

    typedef struct {
        int unsigned cyc;
        int unsigned sig;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic [4:0]  rd_addr1  = '0;
    logic [4:0]  rd_addr2  = '0;
    logic        wr_en     = 1'b0;
    logic [4:0]  wr_addr   = '0;
    logic [31:0] wr_data   = '0;
    logic [3:0]  wr_be     = '0;
    logic        flush_req = 1'b0;

    logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2, c_rd1, c_rd2;
    logic        a_busy, a_done, b_busy, b_done, c_busy, c_done;

    int unsigned cyc    = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    exp_t        sb[$];

    // Config A: defaults (bypass on, zero register on)
    regfile_param #(.DATA_W(32), .NUM_REGS(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(a_rd1), .rd_data2(a_rd2), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be), .flush_req(flush_req),
        .flush_busy(a_busy), .flush_done(a_done)
    );

    // Config B: bypass off
    regfile_param #(.DATA_W(32), .NUM_REGS(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(b_rd1), .rd_data2(b_rd2), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be), .flush_req(flush_req),
        .flush_busy(b_busy), .flush_done(b_done)
    );

    // Config C: 16 registers behind a 5-bit address
    regfile_param #(.DATA_W(32), .NUM_REGS(16), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(c_rd1), .rd_data2(c_rd2), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_be(wr_be), .flush_req(flush_req),
        .flush_busy(c_busy), .flush_done(c_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] observe(input int unsigned sig);
        case (sig)
            S_A_RD1:  return a_rd1;
            S_A_RD2:  return a_rd2;
            S_A_BUSY: return {31'd0, a_busy};
            S_A_DONE: return {31'd0, a_done};
            S_B_RD1:  return b_rd1;
            S_B_RD2:  return b_rd2;
            S_B_BUSY: return {31'd0, b_busy};
            S_B_DONE: return {31'd0, b_done};
            S_C_RD1:  return c_rd1;
            S_C_RD2:  return c_rd2;
            S_C_BUSY: return {31'd0, c_busy};
            S_C_DONE: return {31'd0, c_done};
            default:  return 32'hxxxx_xxxx;
        endcase
    endfunction

    // Monitor: on the falling edge, pop every expectation due this cycle
    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [31:0] got;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e   = sb.pop_front();
            got = observe(e.sig);
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.name, e.cyc, cyc);
            end else if (got !== e.exp) begin
                errors++;
                $display("FAIL %s @cycle %0d: got 0x%08h expected 0x%08h", e.name, cyc, got, e.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_sig(input int unsigned sig, input logic [31:0] val, input string name);
        exp_t e;
        e.cyc  = cyc;
        e.sig  = sig;
        e.exp  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic set_wr(input logic en, input logic [4:0] addr, input logic [31:0] data, input logic [3:0] be);
        wr_en   = en;
        wr_addr = addr;
        wr_data = data;
        wr_be   = be;
    endtask

    initial begin
        // ---- reset state ----
        tick();
        rd_addr1 = 5'd5;
        expect_sig(S_A_RD1, 32'h0, "reset_rd1");
        expect_sig(S_A_BUSY, 32'h0, "reset_busy");
        expect_sig(S_A_DONE, 32'h0, "reset_done");
        tick();
        rst_n = 1'b1;
        expect_sig(S_A_RD1, 32'h0, "post_reset_rd1");

        // ---- full write to r5, bypass vs no bypass ----
        tick();
        set_wr(1'b1, 5'd5, 32'hDEAD_BEEF, 4'hF);
        rd_addr1 = 5'd5;
        expect_sig(S_A_RD1, 32'hDEAD_BEEF, "r5_bypass_same_cycle");
        expect_sig(S_B_RD1, 32'h0, "r5_nobypass_same_cycle");
        tick();
        set_wr(1'b0, 5'd0, 32'h0, 4'h0);
        expect_sig(S_A_RD1, 32'hDEAD_BEEF, "r5_next_cycle");
        expect_sig(S_B_RD1, 32'hDEAD_BEEF, "r5_nobypass_next_cycle");

        // ---- hardwired zero register ----
        tick();
        set_wr(1'b1, 5'd0, 32'h0000_1234, 4'hF);
        rd_addr1 = 5'd0;
        expect_sig(S_A_RD1, 32'h0, "r0_no_bypass");
        tick();
        set_wr(1'b0, 5'd0, 32'h0, 4'h0);
        expect_sig(S_A_RD1, 32'h0, "r0_after_write");

        // ---- byte-enable merge on r7 ----
        tick();
        set_wr(1'b1, 5'd7, 32'h1122_3344, 4'hF);
        tick();
        set_wr(1'b1, 5'd7, 32'hAABB_CCDD, 4'b0101);
        rd_addr1 = 5'd7;
        rd_addr2 = 5'd7;
        expect_sig(S_A_RD1, 32'h11BB_33DD, "r7_merge_bypass");
        expect_sig(S_B_RD1, 32'h1122_3344, "r7_merge_nobypass_old");
        tick();
        set_wr(1'b0, 5'd0, 32'h0, 4'h0);
        expect_sig(S_A_RD2, 32'h11BB_33DD, "r7_merge_stored");
        expect_sig(S_B_RD1, 32'h11BB_33DD, "r7_merge_nobypass_new");

        // ---- bypass of r3 = 0x55, then a be=0 no-op ----
        tick();
        set_wr(1'b1, 5'd3, 32'h0000_0055, 4'hF);
        rd_addr1 = 5'd3;
        expect_sig(S_A_RD1, 32'h55, "r3_bypass");
        expect_sig(S_B_RD1, 32'h0, "r3_nobypass_old");
        tick();
        set_wr(1'b1, 5'd3, 32'hFFFF_FFFF, 4'h0);
        expect_sig(S_B_RD1, 32'h55, "r3_nobypass_new");
        expect_sig(S_A_RD1, 32'h55, "r3_be0_bypass");
        tick();
        set_wr(1'b0, 5'd0, 32'h0, 4'h0);
        expect_sig(S_A_RD1, 32'h55, "r3_be0_stored");

        // ---- out-of-range address on the 16-entry config ----
        tick();
        set_wr(1'b1, 5'd20, 32'h0000_CAFE, 4'hF);
        rd_addr1 = 5'd20;
        rd_addr2 = 5'd5;
        expect_sig(S_C_RD1, 32'h0, "c_addr20_no_bypass");
        expect_sig(S_A_RD1, 32'h0000_CAFE, "a_addr20_bypass");
        expect_sig(S_C_RD2, 32'hDEAD_BEEF, "c_r5_valid");
        tick();
        set_wr(1'b0, 5'd0, 32'h0, 4'h0);
        expect_sig(S_C_RD1, 32'h0, "c_addr20_read");
        expect_sig(S_A_RD1, 32'h0000_CAFE, "a_addr20_stored");
        tick();
        rd_addr1 = 5'd4;
        expect_sig(S_C_RD1, 32'h0, "c_r4_no_alias");

        // ---- fill r1..r31 ----
        for (int i = 1; i < 32; i++) begin
            tick();
            set_wr(1'b1, 5'(i), 32'h100 + 32'(i), 4'hF);
        end

        // ---- flush with a same-cycle write to r9 ----
        tick();
        set_wr(1'b1, 5'd9, 32'h0000_0777, 4'hF);
        flush_req = 1'b1;
        rd_addr1  = 5'd9;
        expect_sig(S_A_RD1, 32'h777, "r9_write_with_flush_req");
        expect_sig(S_A_BUSY, 32'h0, "busy_before_flush");
        for (int m = 1; m <= 32; m++) begin
            tick();
            flush_req = 1'b0;
            if (m != 5) set_wr(1'b0, 5'd0, 32'h0, 4'h0);
            expect_sig(S_A_BUSY, 32'h1, "flush_busy");
            expect_sig(S_A_DONE, 32'h0, "flush_done_early");
            expect_sig(S_B_BUSY, 32'h1, "b_flush_busy");
            if (m <= 16) expect_sig(S_C_BUSY, 32'h1, "c_flush_busy");
            if (m == 17) begin
                expect_sig(S_C_BUSY, 32'h0, "c_flush_busy_end");
                expect_sig(S_C_DONE, 32'h1, "c_flush_done");
            end
            if (m == 5) begin
                set_wr(1'b1, 5'd20, 32'h0000_0099, 4'hF);
                rd_addr1 = 5'd20;
                rd_addr2 = 5'd1;
                expect_sig(S_A_RD1, 32'h114, "busy_write_no_bypass");
                expect_sig(S_B_RD1, 32'h114, "b_busy_write_no_bypass");
                expect_sig(S_A_RD2, 32'h0, "r1_cleared_live");
            end
            if (m == 6) expect_sig(S_A_RD1, 32'h114, "busy_write_dropped");
            if (m == 8) begin
                rd_addr2 = 5'd9;
                expect_sig(S_A_RD2, 32'h777, "r9_live_before_clear");
            end
            if (m == 11) expect_sig(S_A_RD2, 32'h0, "r9_cleared");
            if (m == 32) begin
                rd_addr1 = 5'd31;
                expect_sig(S_A_RD1, 32'h11F, "r31_last_before_clear");
            end
        end
        tick();
        expect_sig(S_A_BUSY, 32'h0, "busy_at_done");
        expect_sig(S_A_DONE, 32'h1, "flush_done_pulse");
        expect_sig(S_A_RD1, 32'h0, "r31_cleared");
        tick();
        expect_sig(S_A_DONE, 32'h0, "flush_done_one_cycle");
        expect_sig(S_A_BUSY, 32'h0, "busy_after_done");
        for (int i = 0; i < 16; i++) begin
            tick();
            rd_addr1 = 5'(2 * i);
            rd_addr2 = 5'(2 * i + 1);
            expect_sig(S_A_RD1, 32'h0, "post_flush_even");
            expect_sig(S_A_RD2, 32'h0, "post_flush_odd");
        end

        // ---- reset in the middle of a flush ----
        tick();
        set_wr(1'b1, 5'd4, 32'h0000_0044, 4'hF);
        tick();
        set_wr(1'b1, 5'd31, 32'h0000_0031, 4'hF);
        tick();
        set_wr(1'b0, 5'd0, 32'h0, 4'h0);
        flush_req = 1'b1;
        for (int m = 1; m <= 9; m++) begin
            tick();
            flush_req = 1'b0;
            expect_sig(S_A_BUSY, 32'h1, "flush2_busy");
            if (m == 9) begin
                rd_addr1 = 5'd31;
                rd_addr2 = 5'd4;
                expect_sig(S_A_RD1, 32'h31, "r31_before_reset");
                expect_sig(S_A_RD2, 32'h0, "r4_cleared_before_reset");
            end
        end
        tick();
        rst_n = 1'b0;
        expect_sig(S_A_BUSY, 32'h0, "reset_midflush_busy");
        expect_sig(S_A_DONE, 32'h0, "reset_midflush_done");
        expect_sig(S_A_RD1, 32'h0, "reset_midflush_r31");
        expect_sig(S_C_BUSY, 32'h0, "c_reset_midflush_busy");
        tick();
        expect_sig(S_A_DONE, 32'h0, "reset_hold_done");
        tick();
        rst_n = 1'b1;
        expect_sig(S_A_BUSY, 32'h0, "reset_release_busy");
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_sig(S_A_DONE, 32'h0, "no_done_after_reset");
            expect_sig(S_A_BUSY, 32'h0, "no_busy_after_reset");
        end

        // ---- fresh flush after reset ----
        tick();
        flush_req = 1'b1;
        for (int m = 1; m <= 32; m++) begin
            tick();
            flush_req = 1'b0;
            expect_sig(S_A_BUSY, 32'h1, "flush3_busy");
            expect_sig(S_A_DONE, 32'h0, "flush3_done_early");
        end
        tick();
        expect_sig(S_A_DONE, 32'h1, "flush3_done");
        expect_sig(S_A_BUSY, 32'h0, "flush3_busy_end");
        tick();
        expect_sig(S_A_DONE, 32'h0, "flush3_done_one_cycle");

        // ---- drain the scoreboard ----
        tick();
        tick();
        @(negedge clk);
        #1;
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: expectation for cycle %0d never checked", e.name, e.cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
Parametrised successor to the single-width MIPS register file. Width, depth, hardwired-zero register and write-to-read bypass are configurable, and writes carry byte enables. Adds a sequential flush engine that clears the whole array one entry per cycle, with busy and done status. Sits in the decode stage of the MIPS core, between the instruction decoder and the ALU operand muxes.

Parameters:
DATA_W, 32, register width in bits; must be a multiple of 8.
NUM_REGS, 32, number of registers; range 2..64.
ADDR_W, 5, address width; must satisfy 2**ADDR_W >= NUM_REGS.
ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes.
BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports.

Ports:
clk  in  1  system clock; all state changes on the rising edge
rst_n  in  1  asynchronous, active-low reset
rd_addr1  in  ADDR_W  read port 1 address
rd_addr2  in  ADDR_W  read port 2 address
rd_data1  out  DATA_W  read port 1 data (combinational)
rd_data2  out  DATA_W  read port 2 data (combinational)
wr_en  in  1  write request
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
wr_be  in  DATA_W/8  byte enables; bit i controls bits [8i+7:8i]
flush_req  in  1  start a full-array clear
flush_busy  out  1  flush in progress; writes are dropped while high
flush_done  out  1  one-cycle pulse when a flush completes

Behaviour:
- Reset (rst_n low, asynchronous): all registers 0; FSM to IDLE; flush pointer 0; flush_busy=0; flush_done=0. Read outputs then return 0.
- Reads: combinational from the current array contents.
  - Address >= NUM_REGS returns 0.
  - With ZERO_REG=1, address 0 returns 0.
- Write acceptance: a write commits on the rising edge when all of the following hold:
  - wr_en=1 and flush_busy=0;
  - wr_addr < NUM_REGS;
  - not (ZERO_REG=1 and wr_addr=0).
- Write effect: only bytes with wr_be[i]=1 are updated; other bytes keep their value. wr_be=0 is a legal no-op. Writes that are not accepted change nothing; no error flag is raised.
- Bypass (BYPASS=1): when a write would be accepted this cycle and rd_addrN equals wr_addr, rd_dataN shows the merged value (new bytes where wr_be=1, stored bytes elsewhere) in the same cycle. There is no bypass for dropped writes, for address 0 when ZERO_REG=1, or while flush_busy=1.
- BYPASS=0: reads return the stored value; the new value is visible from the cycle after the edge.
- Flush FSM states: IDLE, CLEAR, DONE.
  - IDLE: flush_req=1 sampled at edge k -> CLEAR with ptr=0.
  - CLEAR: flush_busy=1. Edge k+j zeroes register j-1 and increments ptr. The edge that clears register NUM_REGS-1 (edge k+NUM_REGS) moves the FSM to DONE.
  - DONE: flush_done=1 for exactly one cycle; flush_busy=0; next edge -> IDLE.
- Flush latency: NUM_REGS cycles busy; flush_done follows immediately after.
- flush_req is ignored in CLEAR and DONE. It is level-sampled only in IDLE, so a request held through DONE starts a new flush on the edge leaving DONE? No: DONE always returns to IDLE first, and the new flush starts on the following edge.
- flush_req and wr_en together in IDLE: the write commits at that edge and the flush starts at the same edge, so the written register is later cleared.
- Reads during CLEAR return live contents: registers already cleared read 0, others keep their old value.
- rst_n asserted mid-flush: immediate return to the reset state; no flush_done pulse.

Decomposition:
- Package regfile_pkg: flush state enum (IDLE, CLEAR, DONE), the byte-merge function (old, new, be) -> merged, and a zero-constant helper.
- One sub-module, regfile_flush_fsm: owns the state register and ptr; outputs flush_busy, flush_done, clr_en and clr_addr. The parent owns the array, the write logic and the bypass mux.

Test Plan:
- Reset, then write r5=0xDEADBEEF with be=1111; read r5 next cycle -> 0xDEADBEEF. Read r0 after a write of 0x1234 to r0 -> 0.
- r7=0x11223344, then write 0xAABBCCDD with be=0101 -> r7=0x11BB33DD.
- BYPASS=1: in the same cycle, write r3=0x55 and read rd_addr1=3 -> rd_data1=0x55 in that cycle. With BYPASS=0 -> old value that cycle, 0x55 the next.
- Fill r1..r31 with nonzero values; pulse flush_req -> flush_busy high for exactly 32 cycles; write of 0x99 to r2 mid-flush is dropped; flush_done pulses once; all registers read 0 afterwards.
- Assert rst_n low at flush cycle 10, mid-edge -> outputs and registers 0 immediately, no flush_done; a new flush after release completes in 32 cycles.
- NUM_REGS=16, ADDR_W=5: write to address 20 is ignored and reading address 20 -> 0.
